// File: rtl/fetch_redirect_unit_if.sv
// Bundle of fetch-side signals: redirect input, instruction-memory request/response,
// the decode-facing output slice, and the FSM state for debug observation.
interface fetch_redirect_unit_if #(
  parameter int XLEN = 32
);
  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
  // A valid source holds its payload stable until that edge; imem_rsp_valid and
  // redirect_valid are single-cycle pulses with no ready.
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            misaligned_err;
  logic [1:0]      dbg_state;

  modport master (
    input  redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, if_ready,
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr, misaligned_err,
           dbg_state
  );

  modport slave (
    output redirect_valid, redirect_target, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, if_ready,
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr, misaligned_err,
           dbg_state
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch PC sequencer: single-outstanding imem requests, one-entry output
// slice to decode, and redirect handling that kills a stale in-flight fetch.
module fetch_redirect_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  fetch_redirect_unit_if.master bus
);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            kill_q, kill_d;
  logic            if_valid_q, if_valid_d;
  logic            req_valid_q, req_valid_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] redirect_pc;

  assign redirect_pc = {bus.redirect_target[XLEN-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    kill_d     = kill_q;
    if_valid_d = if_valid_q;
    mis_d      = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // An accepted request carries the old address; a concurrent redirect makes it stale.
        if (bus.imem_req_ready) begin
          state_d = S_WAIT;
          kill_d  = bus.redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          kill_d = 1'b0;
          if (kill_q || bus.redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_HOLD;
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = bus.imem_rsp_data;
            pc_d       = pc_q + XLEN'(4);
          end
        end else if (bus.redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect flushes decode, so the held word is dropped even if accepted now.
        if (bus.redirect_valid || bus.if_ready) begin
          state_d    = S_REQ;
          if_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.redirect_valid) begin
      pc_d = redirect_pc;
    end

    req_valid_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      if_pc_q     <= '0;
      if_instr_q  <= NOP;
      kill_q      <= 1'b0;
      if_valid_q  <= 1'b0;
      req_valid_q <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      kill_q      <= kill_d;
      if_valid_q  <= if_valid_d;
      req_valid_q <= req_valid_d;
      mis_q       <= mis_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_addr      = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.misaligned_err = mis_q;
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: randomized memory/decode/redirect stimulus checked
// against a transaction-level model of fetch ordering, kill and flush rules.
module tb_fetch_redirect_unit;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_redirect_unit_if #(.XLEN(XLEN)) bus ();

  fetch_redirect_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs (percentages and max response latency)
  int p_ready    = 100;
  int lat_max    = 0;
  int p_redirect = 0;
  int p_ifready  = 100;
  int p_spur     = 0;

  // Memory responder: one outstanding request, response 1+mem_lat cycles after acceptance
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_lat  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A00_0013;
  endfunction

  // Reference model: architectural next-fetch pc, the one outstanding fetch, held instruction
  logic [31:0] m_pc;
  bit          m_out, m_stale, m_idle, m_mis;
  logic [31:0] m_out_addr;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];
  int          n_deliv = 0;
  logic [31:0] last_deliv_pc = '1;
  bit          saw_wrap = 1'b0;

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_out   = 1'b0;
    m_stale = 1'b0;
    m_idle  = 1'b1;
    m_mis   = 1'b0;
    exp_pc_q.delete();
    exp_instr_q.delete();
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {r[31:2], 2'b00};
      1:       return r;
      2:       return 32'hFFFF_FFF0 + {28'd0, r[1:0], 2'b00};
      default: return {24'd0, r[5:0], 2'b00};
    endcase
  endfunction

  task automatic drive(input bit force_rv, input logic [31:0] force_tgt);
    bus.redirect_valid  = force_rv || ($urandom_range(0, 99) < p_redirect);
    bus.redirect_target = force_rv ? force_tgt : pick_target();
    bus.if_ready        = ($urandom_range(0, 99) < p_ifready);
    bus.imem_req_ready  = !mem_busy && ($urandom_range(0, 99) < p_ready);
    if (mem_busy && mem_lat == 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_addr);
    end else begin
      bus.imem_rsp_valid = !mem_busy && ($urandom_range(0, 99) < p_spur);
      bus.imem_rsp_data  = $urandom;
    end
  endtask

  // Called at a negedge with this cycle's inputs applied; returns at the next negedge.
  task automatic cycle();
    bit          rv, req_v, req_r, rsp_v, ifv, ifr, mis;
    logic [31:0] tgt, addr, rsp_d, ifpc, ifins, dpc;
    rv    = bus.redirect_valid;   tgt   = bus.redirect_target;
    req_v = bus.imem_req_valid;   req_r = bus.imem_req_ready;
    addr  = bus.imem_addr;        rsp_v = bus.imem_rsp_valid;
    rsp_d = bus.imem_rsp_data;    ifv   = bus.if_valid;
    ifr   = bus.if_ready;         ifpc  = bus.if_pc;
    ifins = bus.if_instr;         mis   = bus.misaligned_err;

    check_eq("misaligned_err", 32'(mis), 32'(m_mis));
    check_eq("imem_req_valid", 32'(req_v), 32'(!m_idle && !m_out && exp_pc_q.size() == 0));
    if (req_v) check_eq("imem_addr", addr, m_pc);
    check_eq("if_valid", 32'(ifv), 32'(exp_pc_q.size() != 0));
    if (ifv && exp_pc_q.size() != 0) begin
      check_eq("if_pc", ifpc, exp_pc_q[0]);
      check_eq("if_instr", ifins, exp_instr_q[0]);
    end

    if (ifv && ifr && !rv && exp_pc_q.size() != 0) begin
      dpc = exp_pc_q.pop_front();
      void'(exp_instr_q.pop_front());
      n_deliv++;
      if (dpc == 32'h0 && last_deliv_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
      last_deliv_pc = dpc;
    end
    if (rsp_v && m_out) begin
      if (!m_stale && !rv) begin
        exp_pc_q.push_back(m_out_addr);
        exp_instr_q.push_back(rsp_d);
        m_pc = m_out_addr + 32'd4;
      end
      m_out = 1'b0;
    end
    if (req_v && req_r) begin
      m_out      = 1'b1;
      m_out_addr = addr;
      m_stale    = rv;
    end
    if (rv) begin
      m_pc = {tgt[31:2], 2'b00};
      exp_pc_q.delete();
      exp_instr_q.delete();
      if (m_out) m_stale = 1'b1;
    end
    m_mis  = rv && (tgt[1:0] != 2'b00);
    m_idle = 1'b0;

    if (mem_busy) begin
      if (rsp_v) mem_busy = 1'b0;
      else       mem_lat--;
    end
    if (req_v && req_r) begin
      mem_busy = 1'b1;
      mem_addr = addr;
      mem_lat  = $urandom_range(0, lat_max);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive(1'b0, '0);
      cycle();
    end
  endtask

  // Advance until the FSM sits in st, then optionally issue a redirect in that cycle.
  task automatic run_until_state(input logic [1:0] st, input bit do_rv, input logic [31:0] tgt);
    int k = 0;
    while (bus.dbg_state != st && k < 60) begin
      drive(1'b0, '0);
      cycle();
      k++;
    end
    if (k >= 60) begin
      check_eq("reach_state_timeout", 32'(bus.dbg_state), 32'(st));
    end else if (do_rv) begin
      drive(1'b1, tgt);
      cycle();
    end
  endtask

  task automatic reset_checks();
    check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check_eq("rst_imem_addr", bus.imem_addr, RESET_PC);
    check_eq("rst_if_valid", 32'(bus.if_valid), 32'h0);
    check_eq("rst_if_pc", bus.if_pc, 32'h0);
    check_eq("rst_if_instr", bus.if_instr, NOP);
    check_eq("rst_misaligned", 32'(bus.misaligned_err), 32'h0);
    check_eq("rst_state_idle", 32'(bus.dbg_state), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.if_ready        = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    // Zero-wait memory, decode always ready: one instruction every three cycles
    run(12);
    check_eq("throughput_3_per_12", 32'(n_deliv), 32'd3);

    // Memory stalls the request for five cycles
    p_ready = 0;
    run(5);
    p_ready = 100;
    run(6);

    // Redirect during WAIT, during HOLD with if_ready=1, and a misaligned redirect in REQ
    run_until_state(2'd2, 1'b1, 32'h0000_0100);
    run(6);
    run_until_state(2'd3, 1'b1, 32'h0000_0200);
    run(6);
    run_until_state(2'd1, 1'b1, 32'h0000_0102);
    run(6);

    // Sequential fetch across the top of the address space
    saw_wrap = 1'b0;
    run_until_state(2'd1, 1'b1, 32'hFFFF_FFFC);
    run(12);
    check_eq("pc_wrap", 32'(saw_wrap), 32'h1);

    // Randomized traffic with redirects, stalls, latency and spurious responses
    p_redirect = 15; p_ready = 60; lat_max = 3; p_ifready = 70; p_spur = 5;
    run(3000);

    // Asynchronous reset while a fetch is in flight; its response arrives after release
    p_redirect = 0; p_spur = 0; p_ready = 100; p_ifready = 100;
    run_until_state(2'd2, 1'b0, '0);
    if (mem_lat == 0) mem_lat = 2;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lat_max = 0;
    run(15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
